// File: rtl/keycmd_pkg.sv
// Shared types and constants for the keypad command decoder.
// Token payload holds either a digit value or an opcode.
package keycmd_pkg;

   typedef enum logic [1:0] {
      DIGIT = 2'd0,
      OP    = 2'd1,
      ENTER = 2'd2,
      CLEAR = 2'd3
   } cmd_kind_t;

   localparam int PAYLOAD_W = 4;

   localparam logic [3:0] KEY_ADD    = 4'hA;
   localparam logic [3:0] KEY_SUB    = 4'hB;
   localparam logic [3:0] KEY_ENTER  = 4'hC;
   localparam logic [3:0] KEY_MUL    = 4'hD;
   localparam logic [3:0] KEY_CLEAR  = 4'hE;
   localparam logic [3:0] KEY_REPEAT = 4'hF;

   localparam logic [PAYLOAD_W-1:0] OP_NONE  = 4'd0;
   localparam logic [PAYLOAD_W-1:0] OP_ADD   = 4'd1;
   localparam logic [PAYLOAD_W-1:0] OP_SUB   = 4'd2;
   localparam logic [PAYLOAD_W-1:0] OP_ENTER = 4'd3;
   localparam logic [PAYLOAD_W-1:0] OP_MUL   = 4'd4;

   typedef struct packed {
      cmd_kind_t              kind;
      logic [PAYLOAD_W-1:0]   payload;
   } token_t;

endpackage

// File: rtl/keycmd_fifo.sv
// Power-of-two token FIFO with a flush-and-load-one operation.
// flush_load overrides push/pop: storage restarts holding only din.
module keycmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 6
) (
   input  logic                      clk,
   input  logic                      nrst,
   input  logic                      push,
   input  logic                      pop,
   input  logic                      flush_load,
   input  logic [W-1:0]              din,
   output logic [W-1:0]              head,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          wr_en_s;
   logic [AW-1:0] wr_addr_s;

   // Next pointer/count state and write enable.
   always_comb begin
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      wr_en_s   = 1'b0;
      wr_addr_s = wr_ptr_q;
      if (flush_load) begin
         wr_en_s   = 1'b1;
         wr_addr_s = '0;
         rd_ptr_d  = '0;
         wr_ptr_d  = AW'(1);
         count_d   = (AW+1)'(1);
      end else begin
         if (push) begin
            wr_en_s  = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
         end else begin
            wr_en_s  = 1'b0;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Token storage; contents are meaningless outside the occupied window.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[wr_addr_s] <= din;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/keycode_cmd_decoder.sv
// Keypad keycode to command-token decoder feeding a valid/ready token FIFO.
// Define KEYCMD_REPEAT_EN to make key 0xF re-issue the last result opcode.
module keycode_cmd_decoder #(
   parameter int DEPTH = 4,
   parameter int OP_W  = 3
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       key_strobe,
   input  logic [3:0]                 key_code,
   output logic                       cmd_valid,
   input  logic                       cmd_ready,
   output logic [1:0]                 cmd_kind,
   output logic [3:0]                 cmd_digit,
   output logic [OP_W-1:0]            cmd_op,
   output logic                       cmd_is_result,
   output logic                       overflow,
   output logic [OP_W-1:0]            last_op,
   output logic [$clog2(DEPTH):0]     fifo_count
);
   import keycmd_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   token_t          tok_s;
   token_t          head_s;
   logic            cand_s;
   logic            is_clear_s;
   logic            pop_s;
   logic            full_s;
   logic            accept_s;
   logic [CW-1:0]   count_s;
   logic            overflow_q, overflow_d;
   logic [OP_W-1:0] last_op_q, last_op_d;

   // Keycode decode into a candidate token.
   always_comb begin
      tok_s.kind    = DIGIT;
      tok_s.payload = '0;
      cand_s        = 1'b0;
      is_clear_s    = 1'b0;
      if (key_strobe) begin
         case (key_code)
            KEY_ADD:   begin tok_s.kind = OP;    tok_s.payload = OP_ADD;   cand_s = 1'b1; end
            KEY_SUB:   begin tok_s.kind = OP;    tok_s.payload = OP_SUB;   cand_s = 1'b1; end
            KEY_ENTER: begin tok_s.kind = ENTER; tok_s.payload = OP_ENTER; cand_s = 1'b1; end
            KEY_MUL:   begin tok_s.kind = OP;    tok_s.payload = OP_MUL;   cand_s = 1'b1; end
            KEY_CLEAR: begin tok_s.kind = CLEAR; is_clear_s = 1'b1; end
            KEY_REPEAT: begin
`ifdef KEYCMD_REPEAT_EN
               if (last_op_q != '0) begin
                  tok_s.kind    = OP;
                  tok_s.payload = PAYLOAD_W'(last_op_q);
                  cand_s        = 1'b1;
               end else begin
                  cand_s        = 1'b0;
               end
`else
               cand_s = 1'b0;
`endif
            end
            default: begin tok_s.kind = DIGIT; tok_s.payload = key_code; cand_s = 1'b1; end
         endcase
      end else begin
         cand_s = 1'b0;
      end
   end

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign pop_s    = (count_s != '0) && cmd_ready;
   assign full_s   = (count_s == CW'(DEPTH));
   assign accept_s = cand_s && (!full_s || pop_s);

   // Overflow pulse and last result opcode tracking.
   always_comb begin
      overflow_d = cand_s && !accept_s;
      if (accept_s && (tok_s.kind == OP)) begin
         last_op_d = OP_W'(tok_s.payload);
      end else begin
         last_op_d = last_op_q;
      end
   end

   // Status registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         overflow_q <= 1'b0;
         last_op_q  <= '0;
      end else begin
         overflow_q <= overflow_d;
         last_op_q  <= last_op_d;
      end
   end

   keycmd_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(token_t))
   ) u_fifo (
      .clk        (clk),
      .nrst       (nrst),
      .push       (accept_s),
      .pop        (pop_s),
      .flush_load (is_clear_s),
      .din        (tok_s),
      .head       (head_s),
      .count      (count_s)
   );

   // Head presentation; everything reads zero while empty.
   always_comb begin
      cmd_valid     = 1'b0;
      cmd_kind      = 2'd0;
      cmd_digit     = 4'd0;
      cmd_op        = '0;
      cmd_is_result = 1'b0;
      if (count_s != '0) begin
         cmd_valid = 1'b1;
         cmd_kind  = head_s.kind;
         case (head_s.kind)
            DIGIT:   cmd_digit = head_s.payload;
            OP:      begin cmd_op = OP_W'(head_s.payload); cmd_is_result = 1'b1; end
            ENTER:   cmd_op = OP_W'(head_s.payload);
            default: cmd_digit = 4'd0;
         endcase
      end else begin
         cmd_valid = 1'b0;
      end
   end

   assign overflow   = overflow_q;
   assign last_op    = last_op_q;
   assign fifo_count = count_s;

endmodule

// File: doc/keycode_cmd_decoder.md
# keycode_cmd_decoder

Parametrised keypad command decoder: converts each `key_strobe` keycode into a typed command token (DIGIT, OP, ENTER, CLEAR) and buffers the tokens in a DEPTH-entry FIFO. The calculator FSM/ALU drains the FIFO through a valid/ready handshake. The block sits between the keypad scanner and the calculator FSM and replaces single-register opcode latching. Adds multiply, clear-flush, overflow reporting and an optional repeat-last-op key.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- OP_W, 3: opcode width; ≥3.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, asynchronous, active-low.
- key_strobe  in  1  single-cycle keycode-valid pulse.
- key_code  in  4  keycode.
- cmd_valid  out  1  FIFO head valid.
- cmd_ready  in  1  consumer accepts head.
- cmd_kind  out  2  head kind: 0 DIGIT, 1 OP, 2 ENTER, 3 CLEAR.
- cmd_digit  out  4  head digit, valid when kind=DIGIT, else 0.
- cmd_op  out  OP_W  head opcode, valid when kind is OP or ENTER, else 0.
- cmd_is_result  out  1  head is an OP that produces a result (add/sub/mul).
- overflow  out  1  one-cycle pulse: a key was dropped because the FIFO was full.
- last_op  out  OP_W  most recent result opcode pushed; 0 = none.
- fifo_count  out  $clog2(DEPTH)+1  occupancy.

## Operation
Key map, applied only when key_strobe=1:
- 0x0–0x9 → DIGIT, value = key_code.
- 0xA → OP, add (1).
- 0xB → OP, sub (2).
- 0xC → ENTER, op code 3.
- 0xD → OP, mul (4).
- 0xE → CLEAR.
- 0xF → REPEAT (see Configuration).

Push rules:
- A decoded non-CLEAR key is pushed if the FIFO is not full, or if it is full and a pop happens in the same cycle. Otherwise it is dropped and overflow pulses for one cycle.
- Pushing add, sub or mul updates last_op. ENTER, DIGIT and CLEAR do not change it.
- CLEAR always succeeds. It flushes all entries and leaves exactly one CLEAR token, so fifo_count becomes 1. It does not pulse overflow and does not change last_op.

Pop rules:
- A pop happens when cmd_valid && cmd_ready. cmd_valid = (fifo_count != 0).
- Head outputs come combinationally from FIFO storage.
- When the FIFO is empty, all cmd_* outputs are 0.

Simultaneous events:
- Pop together with push: count is unchanged and order is preserved.
- Pop together with CLEAR: the popped head counts as delivered, and the FIFO then holds only CLEAR.
- Empty FIFO with cmd_ready=1: no effect.

Pointer and count arithmetic:
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Count ranges 0..DEPTH.

## Timing
- Reset values: cmd_valid 0, cmd_kind 0, cmd_digit 0, cmd_op 0, cmd_is_result 0, overflow 0, last_op 0, fifo_count 0. Pointers are 0 and storage is don't-care.
- Latency: key_strobe in cycle N makes the token visible at the head in cycle N+1 when the FIFO was empty.
- overflow is registered and asserts in cycle N+1 for a strobe dropped in cycle N.
- Asserting nrst mid-operation discards all entries immediately. No token survives reset.
- key_strobe held high for several cycles is treated as one key per cycle. Debounce belongs upstream.

## Configuration
- KEYCMD_REPEAT_EN defined:
  - 0xF pushes an OP token with opcode = last_op and cmd_is_result=1, following the normal push and overflow rules.
  - If last_op=0, the key is ignored: no push and no overflow.
- KEYCMD_REPEAT_EN undefined: 0xF is ignored like any unmapped key, and the last_op repeat path is not synthesised. last_op is still maintained and output.

## Structure
- Package keycmd_pkg holds:
  - cmd_kind_t enum (DIGIT, OP, ENTER, CLEAR).
  - Keycode constants KEY_ADD, KEY_SUB, KEY_ENTER, KEY_MUL, KEY_CLEAR, KEY_REPEAT.
  - Opcode constants OP_NONE=0, OP_ADD=1, OP_SUB=2, OP_ENTER=3, OP_MUL=4.
  - Packed token struct (kind, payload).
- Sub-module keycmd_fifo:
  - Parametrised by DEPTH and token width.
  - Ports: push, pop, flush_load (flush-and-load-one), head, count.
- The top level holds the key decode, the last_op register and the overflow register.

## Test plan
- Reset, then strobe keys 0x7, 0xA, 0xC with cmd_ready=0 → fifo_count=3. Head sequence: DIGIT 7; OP 1 with is_result=1; ENTER op 3 with is_result=0. last_op=1.
- With DEPTH=4, strobe 5 digits with cmd_ready=0 → count=4, the 5th is dropped, overflow pulses once. Then strobe once more with cmd_ready=1 and the FIFO full → push accepted, count stays 4, no overflow.
- Three tokens queued, then strobe 0xE with cmd_ready=1 in the same cycle → next cycle count=1, head kind=CLEAR, last_op unchanged.
- Strobe 0xD then drain → OP 4 with is_result=1, last_op=4.
- With KEYCMD_REPEAT_EN: 0xF right after reset → no push, no overflow. Then 0xB, 0xF → two OP 2 tokens. Without the macro, 0xF → no push.
- Assert nrst mid-stream with 2 entries queued → cmd_valid=0 and fifo_count=0 immediately (asynchronously). After release, the first strobe appears one cycle later.
